// File: rtl/demux_rr.sv
// Two-way stream splitter: steers each input beat to out_0 or out_1, either by a
// destination bit in the data or by strict alternation. Each output has a 2-entry FIFO.
module demux_rr #(
    parameter int unsigned DWIDTH     = 20,
    parameter bit          ROUTE_MODE = 1'b0,
    parameter int unsigned DEST_BIT   = DWIDTH - 1,
    parameter bit          FIRST_OUT  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic              in_ready,
    output logic              out_0_valid,
    output logic [DWIDTH-1:0] out_0_data,
    input  logic              out_0_ready,
    output logic              out_1_valid,
    output logic [DWIDTH-1:0] out_1_data,
    input  logic              out_1_ready
);

    logic [1:0]        count_q [2];
    logic              wptr_q  [2];
    logic              rptr_q  [2];
    logic [DWIDTH-1:0] mem_q   [2][2];
    logic              rr_q;

    logic       tgt;
    logic       accept;
    logic [1:0] push;
    logic [1:0] pop;

    // in_ready looks only at registered occupancy, never at out_*_ready.
    assign tgt      = ROUTE_MODE ? rr_q : in_data[DEST_BIT];
    assign in_ready = (count_q[tgt] != 2'd2);
    assign accept   = in_valid && in_ready;

    assign push[0] = accept && !tgt;
    assign push[1] = accept && tgt;
    assign pop[0]  = out_0_valid && out_0_ready;
    assign pop[1]  = out_1_valid && out_1_ready;

    assign out_0_valid = (count_q[0] != 2'd0);
    assign out_1_valid = (count_q[1] != 2'd0);
    assign out_0_data  = mem_q[0][rptr_q[0]];
    assign out_1_data  = mem_q[1][rptr_q[1]];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                count_q[i]  <= 2'd0;
                wptr_q[i]   <= 1'b0;
                rptr_q[i]   <= 1'b0;
                mem_q[i][0] <= '0;
                mem_q[i][1] <= '0;
            end
            rr_q <= FIRST_OUT;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    mem_q[i][wptr_q[i]] <= in_data;
                    wptr_q[i]           <= ~wptr_q[i];
                end
                if (pop[i]) begin
                    rptr_q[i] <= ~rptr_q[i];
                end
                if (push[i] && !pop[i]) begin
                    count_q[i] <= count_q[i] + 2'd1;
                end else if (pop[i] && !push[i]) begin
                    count_q[i] <= count_q[i] - 2'd1;
                end
            end
            // Alternation advances only on accepted beats, never on stalls or idles.
            if (accept) begin
                rr_q <= ~rr_q;
            end
        end
    end

endmodule

// File: tb/tb_demux_rr.sv
// Bench for demux_rr: one destination-bit instance and one alternating instance,
// with directed steps and a queue scoreboard checking every output handshake.
module tb_demux_rr;

    logic        clk = 1'b0;
    logic        rst;

    // mode 0 instance
    logic        in_valid, in_ready;
    logic [19:0] in_data;
    logic        o0v, o0r, o1v, o1r;
    logic [19:0] o0d, o1d;

    // mode 1 instance
    logic        m_in_valid, m_in_ready;
    logic [19:0] m_in_data;
    logic        m0v, m0r, m1v, m1r;
    logic [19:0] m0d, m1d;

    int n_checks = 0;
    int n_pass   = 0;

    logic [19:0] q0[$];
    logic [19:0] q1[$];
    logic [19:0] r0[$];
    logic [19:0] r1[$];

    always #5 clk = ~clk;

    demux_rr #(.DWIDTH(20), .ROUTE_MODE(1'b0), .DEST_BIT(19), .FIRST_OUT(1'b0)) u_m0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_0_valid(o0v), .out_0_data(o0d), .out_0_ready(o0r),
        .out_1_valid(o1v), .out_1_data(o1d), .out_1_ready(o1r)
    );

    demux_rr #(.DWIDTH(20), .ROUTE_MODE(1'b1), .DEST_BIT(19), .FIRST_OUT(1'b1)) u_m1 (
        .clk(clk), .rst(rst),
        .in_valid(m_in_valid), .in_data(m_in_data), .in_ready(m_in_ready),
        .out_0_valid(m0v), .out_0_data(m0d), .out_0_ready(m0r),
        .out_1_valid(m1v), .out_1_data(m1d), .out_1_ready(m1r)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one beat into the mode-0 DUT and hold it until accepted (bounded).
    task automatic send0(input logic [19:0] d, output int waited);
        in_valid = 1'b1;
        in_data  = d;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("send0_accept_timeout", {31'd0, in_ready}, 32'd1);
        if (in_ready) begin
            if (d[19]) q1.push_back(d);
            else       q0.push_back(d);
        end
        step();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Drive one beat into the mode-1 DUT; the expected output is given explicitly.
    task automatic send1(input logic [19:0] d, input bit dest);
        m_in_valid = 1'b1;
        m_in_data  = d;
        @(negedge clk);
        chk("m1_in_ready", {31'd0, m_in_ready}, 32'd1);
        if (dest) r1.push_back(d);
        else      r0.push_back(d);
        step();
        m_in_valid = 1'b0;
        m_in_data  = '0;
    endtask

    // Scoreboard: every output handshake must match the oldest expected beat.
    always @(negedge clk) begin
        if (!rst) begin
            if (o0v && o0r) begin
                if (q0.size() == 0) chk("m0_out0_unexpected", {12'd0, o0d}, 32'hFFFF_FFFF);
                else chk("m0_out0_data", {12'd0, o0d}, {12'd0, q0.pop_front()});
            end
            if (o1v && o1r) begin
                if (q1.size() == 0) chk("m0_out1_unexpected", {12'd0, o1d}, 32'hFFFF_FFFF);
                else chk("m0_out1_data", {12'd0, o1d}, {12'd0, q1.pop_front()});
            end
            if (m0v && m0r) begin
                if (r0.size() == 0) chk("m1_out0_unexpected", {12'd0, m0d}, 32'hFFFF_FFFF);
                else chk("m1_out0_data", {12'd0, m0d}, {12'd0, r0.pop_front()});
            end
            if (m1v && m1r) begin
                if (r1.size() == 0) chk("m1_out1_unexpected", {12'd0, m1d}, 32'hFFFF_FFFF);
                else chk("m1_out1_data", {12'd0, m1d}, {12'd0, r1.pop_front()});
            end
        end
    end

    initial begin
        int w;
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_data    = 20'h80001;
        m_in_valid = 1'b1;
        m_in_data  = 20'h0000F;
        o0r = 1'b1; o1r = 1'b1; m0r = 1'b1; m1r = 1'b1;

        // Reset held two edges with in_valid high: nothing may appear.
        step();
        chk("rst1_o0v", {31'd0, o0v}, 32'd0);
        chk("rst1_o1v", {31'd0, o1v}, 32'd0);
        step();
        chk("rst2_o0d", {12'd0, o0d}, 32'd0);
        chk("rst2_o1d", {12'd0, o1d}, 32'd0);
        chk("rst2_m1v", {31'd0, m1v}, 32'd0);
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        m_in_valid = 1'b0;
        m_in_data  = '0;
        step();
        chk("post_rst_o0v", {31'd0, o0v}, 32'd0);
        chk("post_rst_o1v", {31'd0, o1v}, 32'd0);
        chk("post_rst_o0d", {12'd0, o0d}, 32'd0);
        chk("post_rst_o1d", {12'd0, o1d}, 32'd0);
        chk("post_rst_m0v", {31'd0, m0v}, 32'd0);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Steering by bit 19.
        send0(20'h00005, w);
        chk("steer_o0v", {31'd0, o0v}, 32'd1);
        chk("steer_o0d", {12'd0, o0d}, 32'h00005);
        chk("steer_o1v_idle", {31'd0, o1v}, 32'd0);
        send0(20'h80006, w);
        chk("steer_o1v", {31'd0, o1v}, 32'd1);
        chk("steer_o1d", {12'd0, o1d}, 32'h80006);
        chk("steer_o0v_drained", {31'd0, o0v}, 32'd0);
        step();

        // Backpressure: out_1 stalled, third beat must be held.
        o1r = 1'b0;
        send0(20'h80001, w);
        chk("bp_first_nowait", w, 32'd0);
        send0(20'h80002, w);
        chk("bp_second_nowait", w, 32'd0);
        in_valid = 1'b1;
        in_data  = 20'h80003;
        @(negedge clk);
        chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("bp_hold_o1d", {12'd0, o1d}, 32'h80001);
        o1r = 1'b1;
        @(negedge clk);
        chk("bp_full_with_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("bp_after_pop_o1d", {12'd0, o1d}, 32'h80002);
        @(negedge clk);
        chk("bp_slot_freed", {31'd0, in_ready}, 32'd1);
        q1.push_back(20'h80003);
        step();
        in_valid = 1'b0;
        in_data  = '0;
        chk("bp_third_o1d", {12'd0, o1d}, 32'h80003);
        step();
        step();
        chk("bp_drained", {31'd0, o1v}, 32'd0);
        chk("bp_q1_empty", q1.size(), 32'd0);

        // Alternation, FIRST_OUT=1, idle cycle between A and B.
        send1(20'h0000A, 1'b1);
        chk("rr_A_m1d", {12'd0, m1d}, 32'h0000A);
        step();
        send1(20'h0000B, 1'b0);
        chk("rr_B_m0v", {31'd0, m0v}, 32'd1);
        chk("rr_B_m0d", {12'd0, m0d}, 32'h0000B);
        send1(20'h0000C, 1'b1);
        chk("rr_C_m1d", {12'd0, m1d}, 32'h0000C);
        step();

        // Ten back-to-back beats to out_0 with its consumer always ready.
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 20'h00100 + 20'(i);
            @(negedge clk);
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            chk("stream_count_le1", {31'd0, (u_m0.count_q[0] <= 2'd1)}, 32'd1);
            if (i > 0) chk("stream_o0v", {31'd0, o0v}, 32'd1);
            if (in_ready) q0.push_back(in_data);
            step();
        end
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge clk);
        chk("stream_last_o0d", {12'd0, o0d}, 32'h00109);
        step();
        step();
        chk("stream_q0_empty", q0.size(), 32'd0);

        // Reset with out_0 full: contents discarded, both slots usable again.
        o0r = 1'b0;
        send0(20'h00001, w);
        send0(20'h00002, w);
        chk("mid_full_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        q0.delete();
        step();
        rst = 1'b0;
        chk("mid_rst_o0v", {31'd0, o0v}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        send0(20'h00003, w);
        chk("mid_push1_nowait", w, 32'd0);
        chk("mid_push1_o0v", {31'd0, o0v}, 32'd1);
        chk("mid_push1_o0d", {12'd0, o0d}, 32'h00003);
        send0(20'h00004, w);
        chk("mid_push2_nowait", w, 32'd0);
        o0r = 1'b1;
        step();
        step();
        step();
        chk("final_o0v", {31'd0, o0v}, 32'd0);
        chk("final_q0_empty", q0.size(), 32'd0);
        chk("final_r_empty", r0.size() + r1.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/demux_rr.md
# demux_rr

Two-way stream splitter: the distribution counterpart of the two-input round-robin merge arbiter. It accepts one valid/ready stream and steers each beat to one of two output streams. Steering is either by a destination bit carried in the data or by strict alternation. Each output has a 2-entry buffer, so output valid/data are registered and one stalled output does not block beats bound for the other once they are at the head of the input.

## Interface
- DWIDTH, 20: beat width in bits, forwarded unmodified.
- ROUTE_MODE, 0: 0 = route by in_data[DEST_BIT]; 1 = round-robin alternation, ignoring data.
- DEST_BIT, DWIDTH-1: bit index used when ROUTE_MODE=0; 0 selects out_0, 1 selects out_1. Range 0..DWIDTH-1.
- FIRST_OUT, 0: output targeted by the first beat after reset when ROUTE_MODE=1.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_data  in  DWIDTH  input beat.
- in_ready  out  1  input accepted when in_valid && in_ready.
- out_0_valid  out  1  out_0 head beat valid.
- out_0_data  out  DWIDTH  out_0 head beat.
- out_0_ready  in  1  out_0 consumer ready.
- out_1_valid, out_1_data, out_1_ready: same as out_0, for out_1.

## Operation
- Target: ROUTE_MODE=0 gives tgt = in_data[DEST_BIT]. ROUTE_MODE=1 gives tgt = rr register.
- Per output i: 2-entry FIFO with count_i (0..2), 1-bit write pointer and 1-bit read pointer, and 2×DWIDTH storage.
- in_ready = (count_tgt != 2).
  - Depends only on registered count and the target; there is no combinational path from out_i_ready to in_ready.
  - In mode 0, in_ready may depend on in_data.
- Push: in_valid && in_ready writes in_data to FIFO tgt at its write pointer, then advances that pointer.
- Pop_i: out_i_valid && out_i_ready advances read pointer i.
- out_i_valid = (count_i != 0). out_i_data = storage_i[read pointer i]. Both are registered-state driven.
- count_i update: +1 on push only, −1 on pop only, unchanged on push+pop or neither.
- The rr register toggles only on an accepted beat, never on stall or idle cycles. It is unused in mode 0.
- Beats to the same output leave in acceptance order. No ordering is guaranteed between outputs.
- A beat whose target is full blocks the input: head-of-line blocking. The core never drops, duplicates or reorders a beat within an output.

## Timing
- Reset values: count_i=0, pointers=0, storage=0, rr=FIRST_OUT. Hence out_0_valid=0, out_1_valid=0, out_0_data=0, out_1_data=0.
  - in_ready=1 during the cycle following reset, because both FIFOs are empty.
  - in_ready is don't-care while rst is high; inputs are ignored during reset.
- Latency: a beat accepted at edge k is visible on out_tgt at k+1, provided the FIFO was empty.
- Throughput: 1 beat/cycle sustained per output while its consumer holds ready=1, because count oscillates 0→1 and stays at 1.
- Full boundary: count=2 gives in_ready=0 for that target, even if out_tgt_ready=1 in the same cycle. That pop frees the slot at the next edge.
- Empty boundary: count=0 with push → 1. A pop is impossible because valid=0.
- Pointer wrap: 1-bit pointers wrap 1→0 naturally.
- Reset mid-operation: all buffered beats are discarded at the reset edge and outputs drop valid the following cycle. Consumers must tolerate loss of in-flight beats across reset.
- out_i_valid is held with stable out_i_data until popped. This is a valid/ready compliant source.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1, then release.
  - Required: out_*_valid=0 and out_*_data=0 during reset and on the first cycle after release; no beat is emitted.
- Mode 0 steering with DWIDTH=20, DEST_BIT=19: push 0x00005 then 0x80006, both outputs ready.
  - Required: out_0 gets 0x00005 one cycle after its accept; out_1 gets 0x80006 one cycle after its accept.
- Backpressure/full: mode 0, out_1_ready=0, push 3 beats with dest=1 (0x80001, 0x80002, 0x80003).
  - Required: first two accepted, then in_ready=0 with 0x80003 held.
  - Raise out_1_ready: required pop order 0x80001, 0x80002, then 0x80003 accepted one cycle after the first pop and emitted after 0x80002.
- Mode 1 with FIRST_OUT=1: push 0xA, 0xB, 0xC with an idle cycle between 0xA and 0xB.
  - Required: 0xA and 0xC on out_1, 0xB on out_0. The idle cycle does not toggle rr.
- Simultaneous push+pop: stream 10 beats to out_0 with out_0_ready=1 continuously.
  - Required: in_ready stays 1, count_0 stays ≤1, all 10 beats are output in order, one per cycle.
- Reset mid-operation: fill out_0 to 2 beats, assert rst 1 cycle.
  - Required: out_0_valid=0 next cycle, both slots free, and the next push appears after 1 cycle.
